// File: rtl/scan_uart_tx.sv
// scan_uart_tx: packs TDO bits sampled on RTCK rising edges into bytes and returns them to the host as 8N1 serial.
module scan_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          rtck,
    input  logic                          tdo,
    input  logic                          capture_en,
    input  logic                          clr_overflow,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [1:0]           rtck_sync, tdo_sync;
    logic                 rtck_d, rise, push, pop, full, wr_en, tick, tx_n;
    logic [BW-1:0]        bit_cnt, bit_idx, bit_idx_n;
    logic [DATA_BITS-1:0] pack_sr, tx_sr, tx_sr_n;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        timer, timer_n;
    state_t               state, state_n;

    assign rise  = rtck_sync[1] & ~rtck_d;
    assign full  = fifo_count == (AW+1)'(FIFO_DEPTH);
    assign wr_en = push & (~full | pop);
    assign tick  = timer == CW'(CLKS_PER_BIT - 1);
    assign busy  = (state != IDLE) | (fifo_count != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rtck_sync <= '0;
            tdo_sync  <= '0;
            rtck_d    <= 1'b0;
            bit_cnt   <= '0;
            pack_sr   <= '0;
            push      <= 1'b0;
        end else begin
            rtck_sync <= {rtck_sync[0], rtck};
            tdo_sync  <= {tdo_sync[0], tdo};
            rtck_d    <= rtck_sync[1];
            if (!capture_en) begin
                bit_cnt <= '0;
                pack_sr <= '0;
                push    <= 1'b0;
            end else begin
                // the byte is complete after this edge's bit lands, so it is pushed next cycle
                push <= rise && bit_cnt == BW'(DATA_BITS - 1);
                if (rise) begin
                    pack_sr[bit_cnt] <= tdo_sync[1];
                    bit_cnt <= bit_cnt == BW'(DATA_BITS - 1) ? '0 : bit_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= pack_sr;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + (AW+1)'(wr_en) - (AW+1)'(pop);
            overflow   <= (push & full & ~pop) | (overflow & ~clr_overflow);
        end
    end

    always_comb begin
        state_n   = state;
        timer_n   = timer + 1'b1;
        bit_idx_n = bit_idx;
        tx_sr_n   = tx_sr;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                timer_n = '0;
                if (fifo_count != '0) begin
                    pop     = 1'b1;
                    tx_sr_n = mem[rd_ptr];
                    state_n = START;
                end
            end
            START: if (tick) begin
                timer_n   = '0;
                bit_idx_n = '0;
                state_n   = DATA;
            end
            DATA: if (tick) begin
                timer_n   = '0;
                tx_sr_n   = tx_sr >> 1;
                bit_idx_n = bit_idx + 1'b1;
                if (bit_idx == BW'(DATA_BITS - 1)) state_n = STOP;
            end
            STOP: if (tick) begin
                timer_n = '0;
                // chain straight into the next start bit when more bytes wait
                if (fifo_count != '0) begin
                    pop     = 1'b1;
                    tx_sr_n = mem[rd_ptr];
                    state_n = START;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        tx_n = state_n == START ? 1'b0 : state_n == DATA ? tx_sr_n[0] : 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            timer   <= '0;
            bit_idx <= '0;
            tx_sr   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_n;
            timer   <= timer_n;
            bit_idx <= bit_idx_n;
            tx_sr   <= tx_sr_n;
            tx      <= tx_n;
        end
    end
endmodule

// File: tb/tb_scan_uart_tx.sv
// tb_scan_uart_tx: directed stimulus with a serial-decoding monitor that checks frames against a scoreboard queue.
module tb_scan_uart_tx;
    logic       clk = 0, reset_n = 1, rtck = 0, tdo = 0, capture_en = 1, clr_overflow = 0;
    logic       tx, busy, overflow;
    logic [2:0] fifo_count;
    int         tests = 0, fails = 0, cyc = 0, frames = 0;
    logic [7:0] sb [$];
    int         starts [$];

    scan_uart_tx dut (
        .clk(clk), .reset_n(reset_n), .rtck(rtck), .tdo(tdo), .capture_en(capture_en),
        .clr_overflow(clr_overflow), .tx(tx), .busy(busy), .overflow(overflow), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // one rtck period of 4 clk per bit: 2 low with tdo set up, then 2 high
    task automatic send(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tdo  = b[i];
            rtck = 0;
            @(negedge clk);
            @(negedge clk);
            rtck = 1;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        repeat (8) @(negedge clk);
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("drain_busy", busy, 0);
    endtask

    // monitor: decode each frame at mid-bit and compare with the oldest expected byte
    initial begin
        int cnt;
        bit act;
        logic [7:0] d;
        act = 0;
        cnt = 0;
        d = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) act = 0;
            else if (!act) begin
                if (tx === 1'b0) begin
                    act = 1;
                    cnt = 0;
                    starts.push_back(cyc);
                end
            end else begin
                cnt++;
                if (cnt == 8) chk("start_bit", tx, 0);
                else if (cnt >= 24 && cnt <= 136 && cnt % 16 == 8) d[(cnt - 24) / 16] = tx;
                else if (cnt == 152) begin
                    chk("stop_bit", tx, 1);
                    act = 0;
                    frames++;
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_frame: got %0d expected none", d);
                    end else chk("frame_data", d, sb.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n, fb;
        #1 reset_n = 0;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_count", fifo_count, 0);
        reset_n = 1;
        repeat (4) @(negedge clk);

        // single byte 0xA5, full frame length
        starts.delete();
        sb.push_back(8'hA5);
        send(8'hA5, 8);
        wait_idle(2000);
        chk("a5_frame_len", starts.size() > 0 ? cyc - starts[0] : -1, 160);
        chk("a5_sb_empty", sb.size(), 0);
        chk("a5_tx_idle", tx, 1);

        // back-to-back frames with no idle gap
        starts.delete();
        sb.push_back(8'h00);
        sb.push_back(8'hFF);
        send(8'h00, 8);
        send(8'hFF, 8);
        wait_idle(2000);
        chk("b2b_frames", starts.size(), 2);
        chk("b2b_gap", starts.size() > 1 ? starts[1] - starts[0] : -1, 160);
        chk("b2b_sb_empty", sb.size(), 0);

        // partial byte discarded when capture_en drops
        send(8'h1F, 5);
        @(negedge clk);
        capture_en = 0;
        repeat (4) @(negedge clk);
        capture_en = 1;
        sb.push_back(8'h3C);
        send(8'h3C, 8);
        wait_idle(2000);
        chk("partial_sb_empty", sb.size(), 0);

        // six bytes at full rtck rate: five transmitted, sixth dropped
        for (int i = 1; i <= 5; i++) sb.push_back(8'(i * 8'h11));
        for (int i = 1; i <= 6; i++) send(8'(i * 8'h11), 8);
        repeat (8) @(negedge clk);
        chk("ovf_set", overflow, 1);
        chk("ovf_count", fifo_count, 3);
        wait_idle(3000);
        chk("ovf_sticky", overflow, 1);
        chk("ovf_sb_empty", sb.size(), 0);
        clr_overflow = 1;
        @(negedge clk);
        clr_overflow = 0;
        chk("ovf_cleared", overflow, 0);

        // one extra clk before the sixth byte lines its push up with the pop
        for (int i = 1; i <= 6; i++) sb.push_back(8'(8'hF0 | i));
        for (int i = 1; i <= 5; i++) send(8'(8'hF0 | i), 8);
        @(negedge clk);
        send(8'hF6, 8);
        repeat (8) @(negedge clk);
        chk("coinc_count", fifo_count, 4);
        chk("coinc_no_ovf", overflow, 0);
        wait_idle(3000);
        chk("coinc_sb_empty", sb.size(), 0);
        chk("coinc_no_ovf_end", overflow, 0);

        // asynchronous reset in the middle of the data bits
        starts.delete();
        sb.push_back(8'h5A);
        send(8'h5A, 8);
        n = 0;
        while (starts.size() == 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rst_frame_started", starts.size(), 1);
        repeat (60) @(negedge clk);
        chk("mid_tx_low", tx, 0);
        reset_n = 0;
        #1;
        chk("arst_tx", tx, 1);
        chk("arst_busy", busy, 0);
        chk("arst_count", fifo_count, 0);
        chk("arst_overflow", overflow, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1;
        sb.delete();
        fb = frames;
        repeat (300) @(negedge clk);
        chk("arst_no_frame", frames, fb);
        chk("arst_tx_idle", tx, 1);
        chk("arst_busy_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
